// File: rtl/fc_cif_0_1_sdiv_32s_32s_32_seq.sv
// rtl/fc_cif_0_1_sdiv_32s_32s_32_seq.sv - iterative restoring signed divider, one quotient bit per enabled cycle
// Optional FC_CIF_SDIV_ZERO_CHECK_EN: zero divisor bypasses the loop and returns a saturated quotient.
module fc_cif_0_1_sdiv_32s_32s_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int N  = dout_WIDTH;
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (din0_WIDTH != dout_WIDTH || din1_WIDTH != dout_WIDTH || ID < 0) begin : g_cfg_err
    $error("fc_cif sdiv: operand widths must equal dout_WIDTH");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  r_q, r_d;       // partial remainder
  logic [N-1:0]  q_q, q_d;       // dividend shifting out, quotient shifting in
  logic [N-1:0]  dvs_q, dvs_d;   // divisor magnitude
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          zero_q, zero_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  abs0, abs1;
  logic [N:0]    shifted;
  logic          ge;
  logic [N-1:0]  diff;
  logic          din1_zero;

  // Unsigned N-bit negation keeps |-2^(N-1)| = 2^(N-1) exact.
  assign abs0      = din0[N-1] ? (~din0 + 1'b1) : din0;
  assign abs1      = din1[N-1] ? (~din1 + 1'b1) : din1;
  assign shifted   = {r_q, q_q[N-1]};
  assign ge        = (shifted >= {1'b0, dvs_q});
  assign diff      = shifted[N-1:0] - dvs_q;
  assign din1_zero = (din1 == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d     = abs0;
          dvs_d   = abs1;
          r_d     = '0;
          cnt_d   = '0;
          neg_q_d = din0[N-1] ^ din1[N-1];
          neg_r_d = din0[N-1];
          busy_d  = 1'b1;
          zero_d  = 1'b0;
          state_d = S_CALC;
`ifdef FC_CIF_SDIV_ZERO_CHECK_EN
          if (din1_zero) begin
            // Preloading |din0| lets the normal sign fix reproduce din0 as the remainder.
            r_d     = abs0;
            zero_d  = 1'b1;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        r_d   = ge ? diff : shifted[N-1:0];
        q_d   = {q_q[N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = neg_q_q ? (~q_q + 1'b1) : q_q;
        rem_d   = neg_r_q ? (~r_q + 1'b1) : r_q;
        dbz_d   = zero_q;
        if (zero_q) begin
          quot_d = neg_r_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef FC_CIF_SDIV_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (ce) begin
      zero_q <= zero_d;
      dbz_q  <= dbz_d;
    end
  end
  assign div_by_zero = dbz_q;
`else
  assign zero_q      = 1'b0;
  assign dbz_q       = 1'b0;
  assign div_by_zero = 1'b0;
  logic unused_zero;
  assign unused_zero = ^{zero_d, dbz_d, din1_zero};
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_fc_cif_0_1_sdiv_32s_32s_32_seq.sv
// tb/tb_fc_cif_0_1_sdiv_32s_32s_32_seq.sv - scoreboard bench for the iterative signed divider
// Honours FC_CIF_SDIV_ZERO_CHECK_EN for zero-divisor expectations.
module tb_fc_cif_0_1_sdiv_32s_32s_32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [31:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quot, rem;

  fc_cif_0_1_sdiv_32s_32s_32_seq #(
    .ID(1), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   ce_rand = 1'b0;
  int   en_cnt = 0;
  int   acc_q = 0;
  int   busy_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncated back to 32 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (b == 32'd0) begin
`ifdef FC_CIF_SDIV_ZERO_CHECK_EN
      e.q   = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dz  = 1'b1;
      e.lat = 2;
`else
      e.q   = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      e.dz  = 1'b0;
      e.lat = 34;
`endif
      e.r = a;
    end else begin
      e.q   = 32'(sa / sbv);
      e.r   = 32'(sa % sbv);
      e.dz  = 1'b0;
      e.lat = 34;
    end
    return e;
  endfunction

  // Enabled-edge bookkeeping; a request is taken when start meets an idle, enabled DUT.
  always @(posedge clk) begin
    if (!reset && ce) begin
      en_cnt <= en_cnt + 1;
      if (start && !busy) begin
        acc_q   <= en_cnt;
        busy_en <= 0;
      end else if (busy) begin
        busy_en <= busy_en + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expectation per rising done.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("quot", quot, e.q);
          chk("rem", rem, e.r);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
          chk("latency", 32'(en_cnt - acc_q), 32'(e.lat));
          chk("busy_cycles", 32'(busy_en), 32'(e.lat - 1));
          chk("busy_at_done", {31'b0, busy}, 32'd1);
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit mid_start);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (ce && !busy && !reset) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) sb.push_back(model(a, b));
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    @(negedge clk);
    start = 1'b0;
    if (mid_start) begin
      repeat (10) @(negedge clk);
      din0  = $urandom;
      din1  = $urandom_range(1, 9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b, 1'b0);
    drain();
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    run(32'd100, 32'd7);
    run(-32'sd100, 32'd7);
    run(32'd100, -32'sd7);
    run(32'h8000_0000, 32'hFFFF_FFFF);
    run(32'h8000_0000, 32'd1);
    run(32'd5, 32'd0);
    run(-32'sd5, 32'd0);
    run(32'h7FFF_FFFF, 32'h8000_0000);

    ce_rand = 1'b1;
    issue(32'd1000, 32'd3, 1'b1);
    drain();
    for (int k = 0; k < 30; k++) begin
      a = (k % 3 == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      endcase
      run(a, b);
    end

    ce_rand = 1'b0;
    @(negedge clk);
    issue(32'd2000, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_quot", quot, 32'd0);
    chk("mid_rst_rem", rem, 32'd0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    run(32'd1000, 32'd3);
    run(-32'sd123456, -32'sd789);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
